my_capture_buffer: RTL and testbench
====================================

MY_CAPTURE_BUFFER -- requirements
Module: my_capture_buffer

Interface
REQ-001: Parameter DEPTH_LOG2, default 10, log2 of capture RAM depth in 32-bit words (DEPTH = 2**DEPTH_LOG2).
REQ-002: csi_clk  in  1  sole clock; all logic on rising edge.
REQ-003: rsi_reset_n  in  1  reset; synchronous, active-low.
REQ-004: asi_in0_data  in  32  packed sample pair, ch0 in [11:0], ch1 in [27:16].
REQ-005: asi_in0_valid  in  1  word qualifier; no backpressure, never stalled.
REQ-006: avs_s0_address  in  3  register select.
REQ-007: avs_s0_read  in  1  read strobe.
REQ-008: avs_s0_write  in  1  write strobe.
REQ-009: avs_s0_writedata  in  32  write data.
REQ-010: avs_s0_readdata  out  32  read data, fixed read latency 2.
REQ-011: ins_irq0_irq  out  1  level interrupt, high while DONE and IRQ_EN.

Function
REQ-012: Registers: 0 CTRL (W: bit0 START pulse, bit1 ABORT pulse, bit2 TRIG_EN, bit3 IRQ_EN; R: bits[3:2]), 1 STATUS (R), 2 DECIM [15:0], 3 LENGTH [DEPTH_LOG2:0], 4 TRIG_LEVEL [11:0], 5 DATA (R), 6 RDPTR [DEPTH_LOG2-1:0] (R/W).
REQ-013: STATUS: bit0 busy (ARMED or CAPTURE), bit1 done, bit2 triggered, bits[16+DEPTH_LOG2:16] stored-word count.
REQ-014: FSM states IDLE, ARMED, CAPTURE, DONE.
REQ-015: START write from any state -> ARMED; clears count, done, triggered, decimation counter; RDPTR -> 0.
REQ-016: ABORT write from any state -> IDLE; count and RAM contents retained; ABORT wins over simultaneous START.
REQ-017: ARMED with TRIG_EN=0 -> CAPTURE next cycle; the first stored word is the first valid word accepted in CAPTURE.
REQ-018: ARMED with TRIG_EN=1: trigger on a valid word whose ch0 >= TRIG_LEVEL while previous valid word (received in ARMED) had ch0 < TRIG_LEVEL; the triggering word is stored as word 0, triggered set, state -> CAPTURE.
REQ-019: First valid word in ARMED only seeds the previous-sample register; no trigger on it.
REQ-020: CAPTURE: decimation counter counts valid words; a word is stored when counter == 0, counter wraps after DECIM, i.e. one of every DECIM+1 words stored; DECIM=0 stores every word.
REQ-021: Stored word written to RAM at address = count, count incremented same cycle.
REQ-022: Effective length L = DEPTH when LENGTH == 0 or LENGTH > DEPTH, else LENGTH; state -> DONE on the cycle the L-th word is stored.
REQ-023: DONE -> IDLE only by ABORT; START restarts.
REQ-024: Valid words outside ARMED/CAPTURE ignored.
REQ-025: DECIM, LENGTH, TRIG_LEVEL writes take effect immediately, including mid-capture.
REQ-026: DATA read returns RAM[RDPTR] with latency 2, RDPTR increments modulo DEPTH on the read cycle; back-to-back DATA reads return consecutive words.
REQ-027: RDPTR write and DATA read same cycle: read uses old RDPTR, written value wins.
REQ-028: RAM read-during-write to same address returns old data.
REQ-029: Reads of unused address 7 return 0; writes ignored.

Reset
REQ-030: On reset: state IDLE, all registers 0, count 0, RDPTR 0, avs_s0_readdata 0, ins_irq0_irq 0; RAM contents undefined.
REQ-031: Reset mid-capture aborts without further RAM writes from the next edge; reset overrides START.

Structure
REQ-032: Package my_capture_pkg holds register offsets, CTRL/STATUS bit positions, FSM state encoding.
REQ-033: One sub-module my_capture_ram: simple dual-port, one write port, one registered read port, DEPTH x 32.

Verification
REQ-034: TRIG_EN=0, DECIM=0, LENGTH=4, START, feed 6 valid words 0x0001_0001..0x0006_0006 -> DONE after 4th, DATA reads return 0x0001_0001..0x0004_0004, STATUS count 4.
REQ-035: TRIG_EN=1, TRIG_LEVEL=0x800, ch0 sequence 0x100,0x7FF,0x800,0x900 -> word 0 = ch0 0x800, triggered=1.
REQ-036: DECIM=2, LENGTH=3, 9 words ch0=0..8 -> stored ch0 0,3,6; DONE.
REQ-037: LENGTH=0, DEPTH_LOG2=4 -> DONE after 16 words; 17th DATA read wraps to word 0.
REQ-038: ABORT and START same cycle during CAPTURE -> IDLE, count unchanged; reset low mid-capture -> IDLE, STATUS 0, irq 0.

Source files
------------

// File: rtl/my_capture_pkg.sv
// Shared register map, control/status bit positions and FSM encoding
// for the capture buffer.
package my_capture_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_DECIM  = 3'd2;
  localparam logic [2:0] REG_LENGTH = 3'd3;
  localparam logic [2:0] REG_TRIG   = 3'd4;
  localparam logic [2:0] REG_DATA   = 3'd5;
  localparam logic [2:0] REG_RDPTR  = 3'd6;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_TRIG_EN = 2;
  localparam int CTRL_IRQ_EN  = 3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_TRIG      = 2;
  localparam int STAT_COUNT_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/my_capture_if.sv
// Register bus and sample stream of the capture buffer. The master side is
// the host plus the sample source; the slave side is the buffer itself.
interface my_capture_if;

  logic [2:0]  avs_s0_address;
  logic        avs_s0_read;
  logic        avs_s0_write;
  logic [31:0] avs_s0_writedata;
  logic [31:0] avs_s0_readdata;
  logic [31:0] asi_in0_data;
  logic        asi_in0_valid;

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    output asi_in0_data, asi_in0_valid,
    input  avs_s0_readdata
  );

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    input  asi_in0_data, asi_in0_valid,
    output avs_s0_readdata
  );

endinterface

// File: rtl/my_capture_ram.sv
// Simple dual-port capture memory: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module my_capture_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              csi_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_r [0:(1<<ADDR_W)-1];

  // Write port and registered read port; NBA ordering yields old-data reads.
  always_ff @(posedge csi_clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/my_capture_buffer.sv
// Triggered, decimating sample capture into on-chip RAM, with a small
// register file for control, status and sequential readback.
module my_capture_buffer
  import my_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  my_capture_if.slave s0,
  output logic        ins_irq0_irq
);

  localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};

  cap_state_e            state_r;
  logic                  trig_en_r, irq_en_r, triggered_r, prev_vld_r, irq_r;
  logic [15:0]           decim_r, decim_cnt_r, decim_nxt_s;
  logic [DEPTH_LOG2:0]   length_r, count_r, count_inc_s, eff_len_s;
  logic [11:0]           trig_lvl_r, prev_ch0_r, ch0_s;
  logic [DEPTH_LOG2-1:0] rdptr_r;
  logic                  ctrl_wr_s, start_s, abort_s, trig_hit_s, store_s, ram_we_s;
  logic                  rd_vld_r, rd_data_r;
  logic [31:0]           rd_reg_r, reg_rd_s, status_s, ram_q_s, readdata_r;
  logic                  unused_wdata_s;

  assign unused_wdata_s = ^s0.avs_s0_writedata[31:16];

  // Command decode, effective length and store/trigger qualification.
  always_comb begin
    ch0_s       = s0.asi_in0_data[11:0];
    ctrl_wr_s   = s0.avs_s0_write && (s0.avs_s0_address == REG_CTRL);
    abort_s     = ctrl_wr_s && s0.avs_s0_writedata[CTRL_ABORT];
    start_s     = ctrl_wr_s && s0.avs_s0_writedata[CTRL_START] && !s0.avs_s0_writedata[CTRL_ABORT];
    count_inc_s = count_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
    decim_nxt_s = (decim_cnt_r >= decim_r) ? 16'd0 : decim_cnt_r + 16'd1;
    trig_hit_s  = s0.asi_in0_valid && prev_vld_r && (prev_ch0_r < trig_lvl_r) && (ch0_s >= trig_lvl_r);
    if ((length_r == {(DEPTH_LOG2+1){1'b0}}) || (length_r > DEPTH_C)) begin
      eff_len_s = DEPTH_C;
    end else begin
      eff_len_s = length_r;
    end
    store_s = 1'b0;
    if (start_s || abort_s) begin
      store_s = 1'b0;
    end else begin
      case (state_r)
        ST_ARMED:   store_s = trig_en_r && trig_hit_s;
        ST_CAPTURE: store_s = s0.asi_in0_valid && (decim_cnt_r == 16'd0);
        default:    store_s = 1'b0;
      endcase
    end
    ram_we_s = store_s && rsi_reset_n;
  end

  // Configuration registers; writes apply immediately, even mid-capture.
  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      trig_en_r  <= 1'b0;
      irq_en_r   <= 1'b0;
      decim_r    <= 16'd0;
      length_r   <= '0;
      trig_lvl_r <= 12'd0;
    end else if (s0.avs_s0_write) begin
      case (s0.avs_s0_address)
        REG_CTRL: begin
          trig_en_r <= s0.avs_s0_writedata[CTRL_TRIG_EN];
          irq_en_r  <= s0.avs_s0_writedata[CTRL_IRQ_EN];
        end
        REG_DECIM:  decim_r    <= s0.avs_s0_writedata[15:0];
        REG_LENGTH: length_r   <= s0.avs_s0_writedata[DEPTH_LOG2:0];
        REG_TRIG:   trig_lvl_r <= s0.avs_s0_writedata[11:0];
        default:    ;
      endcase
    end
  end

  // Capture FSM with its word count, decimation and trigger history.
  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      triggered_r <= 1'b0;
      decim_cnt_r <= 16'd0;
      prev_vld_r  <= 1'b0;
      prev_ch0_r  <= 12'd0;
    end else if (abort_s) begin
      state_r <= ST_IDLE;
    end else if (start_s) begin
      state_r     <= ST_ARMED;
      count_r     <= '0;
      triggered_r <= 1'b0;
      decim_cnt_r <= 16'd0;
      prev_vld_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_ARMED: begin
          if (!trig_en_r) begin
            state_r <= ST_CAPTURE;
          end else if (store_s) begin
            // The trigger word occupies decimation slot 0.
            triggered_r <= 1'b1;
            count_r     <= count_inc_s;
            decim_cnt_r <= (decim_r == 16'd0) ? 16'd0 : 16'd1;
            state_r     <= (count_inc_s >= eff_len_s) ? ST_DONE : ST_CAPTURE;
          end else if (s0.asi_in0_valid) begin
            prev_ch0_r <= ch0_s;
            prev_vld_r <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (s0.asi_in0_valid) begin
            decim_cnt_r <= decim_nxt_s;
          end
          if (store_s) begin
            count_r <= count_inc_s;
            if (count_inc_s >= eff_len_s) begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_IDLE: ;
        ST_DONE: ;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  my_capture_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .csi_clk (csi_clk),
    .we      (ram_we_s),
    .waddr   (count_r[DEPTH_LOG2-1:0]),
    .wdata   (s0.asi_in0_data),
    .raddr   (rdptr_r),
    .rdata   (ram_q_s)
  );

  // Register read multiplexer and status word assembly.
  always_comb begin
    status_s = 32'd0;
    status_s[STAT_BUSY] = (state_r == ST_ARMED) || (state_r == ST_CAPTURE);
    status_s[STAT_DONE] = (state_r == ST_DONE);
    status_s[STAT_TRIG] = triggered_r;
    status_s[STAT_COUNT_LSB +: DEPTH_LOG2+1] = count_r;
    case (s0.avs_s0_address)
      REG_CTRL:   reg_rd_s = {28'd0, irq_en_r, trig_en_r, 2'b00};
      REG_STATUS: reg_rd_s = status_s;
      REG_DECIM:  reg_rd_s = {16'd0, decim_r};
      REG_LENGTH: reg_rd_s = 32'(length_r);
      REG_TRIG:   reg_rd_s = {20'd0, trig_lvl_r};
      REG_RDPTR:  reg_rd_s = 32'(rdptr_r);
      default:    reg_rd_s = 32'd0;
    endcase
  end

  // Read pointer and the two-stage read-data pipeline; a pointer write beats
  // the increment of a concurrent DATA read.
  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      rdptr_r    <= '0;
      rd_vld_r   <= 1'b0;
      rd_data_r  <= 1'b0;
      rd_reg_r   <= 32'd0;
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      if (start_s) begin
        rdptr_r <= '0;
      end else if (s0.avs_s0_write && (s0.avs_s0_address == REG_RDPTR)) begin
        rdptr_r <= s0.avs_s0_writedata[DEPTH_LOG2-1:0];
      end else if (s0.avs_s0_read && (s0.avs_s0_address == REG_DATA)) begin
        rdptr_r <= rdptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      end
      rd_vld_r   <= s0.avs_s0_read;
      rd_data_r  <= s0.avs_s0_read && (s0.avs_s0_address == REG_DATA);
      rd_reg_r   <= reg_rd_s;
      readdata_r <= !rd_vld_r ? 32'd0 : (rd_data_r ? ram_q_s : rd_reg_r);
      irq_r      <= (state_r == ST_DONE) && irq_en_r;
    end
  end

  assign s0.avs_s0_readdata = readdata_r;
  assign ins_irq0_irq       = irq_r;

endmodule

// File: tb/tb_my_capture_buffer.sv
// Directed plus randomized checks of my_capture_buffer against a
// list-based reference model of which samples end up stored.
module tb_my_capture_buffer;

  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam logic [2:0] A_CTRL = 3'd0, A_STAT = 3'd1, A_DECIM = 3'd2, A_LEN = 3'd3;
  localparam logic [2:0] A_TRIG = 3'd4, A_DATA = 3'd5, A_RDPTR = 3'd6, A_NONE = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  int checks = 0;
  int errors = 0;
  logic [31:0] stim_q[$];
  logic [31:0] exp_q[$];
  logic exp_trig;

  my_capture_if bus_if ();

  my_capture_buffer #(.DEPTH_LOG2(DL)) dut (
    .csi_clk      (clk),
    .rsi_reset_n  (rst_n),
    .s0           (bus_if.slave),
    .ins_irq0_irq (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus_if.avs_s0_address = a; bus_if.avs_s0_writedata = d; bus_if.avs_s0_write = 1'b1;
    @(posedge clk); #1;
    bus_if.avs_s0_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus_if.avs_s0_address = a; bus_if.avs_s0_read = 1'b1;
    @(posedge clk); #1;
    bus_if.avs_s0_read = 1'b0;
    @(posedge clk); #1;
    d = bus_if.avs_s0_readdata;
  endtask

  task automatic feed_all();
    foreach (stim_q[i]) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1;
      bus_if.asi_in0_data = stim_q[i]; bus_if.asi_in0_valid = 1'b1;
      @(posedge clk); #1;
      bus_if.asi_in0_valid = 1'b0; bus_if.asi_in0_data = $urandom;
    end
  endtask

  // Reference: locate the trigger point, then keep every (decim+1)-th word up to L.
  function automatic void model(input bit trig_en, input int lvl, input int decim, input int len);
    int l, first;
    bit found;
    l = (len == 0 || len > DEPTH) ? DEPTH : len;
    exp_q.delete();
    first = 0;
    found = !trig_en;
    if (trig_en) begin
      for (int k = 1; k < stim_q.size(); k++) begin
        if (!found && int'(stim_q[k-1] & 32'hFFF) < lvl && int'(stim_q[k] & 32'hFFF) >= lvl) begin
          found = 1'b1;
          first = k;
        end
      end
    end
    exp_trig = trig_en && found;
    if (found) begin
      for (int j = first; j < stim_q.size() && exp_q.size() < l; j++) begin
        if ((j - first) % (decim + 1) == 0) exp_q.push_back(stim_q[j]);
      end
    end
  endfunction

  task automatic run_capture(input string tag, input bit trig_en, input int lvl,
                             input int decim, input int len, input bit irq_en);
    logic [31:0] d, st;
    int l;
    bit done;
    l = (len == 0 || len > DEPTH) ? DEPTH : len;
    wr(A_DECIM, 32'(decim));
    wr(A_LEN, 32'(len));
    wr(A_TRIG, 32'(lvl));
    wr(A_CTRL, 32'h1 | (32'(trig_en) << 2) | (32'(irq_en) << 3));
    repeat (2) @(posedge clk);
    feed_all();
    model(trig_en, lvl, decim, len);
    done = (exp_q.size() == l);
    st = (32'(exp_q.size()) << 16) | (32'(exp_trig) << 2) | (32'(done) << 1) | 32'(!done);
    rd(A_STAT, d);
    chk({tag, "_status"}, d, st);
    chk({tag, "_irq"}, 32'(irq), 32'(irq_en && done));
    wr(A_RDPTR, 32'h0);
    foreach (exp_q[i]) begin
      rd(A_DATA, d);
      chk($sformatf("%s_data%0d", tag, i), d, exp_q[i]);
    end
  endtask

  initial begin
    logic [31:0] d;
    bus_if.avs_s0_address = 3'd0; bus_if.avs_s0_read = 1'b0; bus_if.avs_s0_write = 1'b0;
    bus_if.avs_s0_writedata = 32'd0; bus_if.asi_in0_data = 32'd0; bus_if.asi_in0_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_readdata", bus_if.avs_s0_readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      if (a != 5) begin
        rd(3'(a), d);
        chk($sformatf("rst_reg%0d", a), d, 32'd0);
      end
    end

    // Free-running capture of four words out of six.
    stim_q.delete();
    for (int i = 1; i <= 6; i++) stim_q.push_back(32'(i) | (32'(i) << 16));
    run_capture("basic", 1'b0, 0, 0, 4, 1'b1);
    rd(A_DATA, d);
    chk("basic_word0_val", exp_q[0], 32'h0001_0001);

    // Rising-edge trigger at 0x800.
    stim_q.delete();
    stim_q.push_back(32'h0000_0100 | ($urandom & 32'h0FFF_0000));
    stim_q.push_back(32'h0000_07FF | ($urandom & 32'h0FFF_0000));
    stim_q.push_back(32'h0000_0800 | ($urandom & 32'h0FFF_0000));
    stim_q.push_back(32'h0000_0900 | ($urandom & 32'h0FFF_0000));
    run_capture("trig", 1'b1, 32'h800, 0, 0, 1'b0);
    wr(A_RDPTR, 32'h0);
    rd(A_DATA, d);
    chk("trig_word0_ch0", d & 32'hFFF, 32'h800);

    // Decimate by three.
    stim_q.delete();
    for (int i = 0; i < 9; i++) stim_q.push_back(32'(i) | ($urandom & 32'h0FFF_0000));
    run_capture("decim", 1'b0, 0, 2, 3, 1'b0);

    // Full-depth capture and read-pointer wrap.
    stim_q.delete();
    for (int i = 0; i < 20; i++) stim_q.push_back($urandom);
    run_capture("full", 1'b0, 0, 0, 0, 1'b0);
    rd(A_DATA, d);
    chk("full_wrap", d, stim_q[0]);
    wr(A_RDPTR, 32'd5);
    rd(A_DATA, d);
    chk("rdptr_set", d, stim_q[5]);
    wr(A_NONE, 32'hFFFF_FFFF);
    rd(A_NONE, d);
    chk("addr7", d, 32'd0);

    // Randomized configurations.
    for (int r = 0; r < 4; r++) begin
      stim_q.delete();
      for (int i = 0; i < 24; i++) stim_q.push_back($urandom & 32'h0FFF_0FFF);
      run_capture($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), $urandom_range(1, 4095),
                  $urandom_range(0, 3), $urandom_range(0, 20), 1'b1);
    end

    // ABORT together with START mid-capture.
    stim_q.delete();
    for (int i = 0; i < 3; i++) stim_q.push_back($urandom);
    wr(A_LEN, 32'd0);
    wr(A_DECIM, 32'd0);
    wr(A_CTRL, 32'h9);
    repeat (2) @(posedge clk);
    feed_all();
    wr(A_CTRL, 32'h3);
    feed_all();
    rd(A_STAT, d);
    chk("abort_status", d, 32'h0003_0000);
    chk("abort_irq", 32'(irq), 32'd0);

    // Reset in the middle of a capture.
    wr(A_CTRL, 32'h1);
    repeat (2) @(posedge clk);
    feed_all();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_readdata", bus_if.avs_s0_readdata, 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    rd(A_STAT, d);
    chk("midrst_status", d, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
